// File: rtl/cam_rgb565_capture_pkg.sv
// Shared constants for the camera capture path: frame geometry, FSM states and the
// RGB565 -> RGB444 bit-slice positions.
package cam_rgb565_capture_pkg;

  localparam int unsigned FRAME_W      = 160;
  localparam int unsigned FRAME_H      = 120;
  localparam int unsigned FRAME_PIXELS = FRAME_W * FRAME_H;

  // byte1 = RRRRRGGG, byte2 = GGGBBBBB; keep the top 4 bits of each channel
  localparam int unsigned R_HI   = 7;
  localparam int unsigned R_LO   = 4;
  localparam int unsigned G1_HI  = 2;
  localparam int unsigned G1_LO  = 0;
  localparam int unsigned G2_BIT = 7;
  localparam int unsigned B_HI   = 4;
  localparam int unsigned B_LO   = 1;

  typedef enum logic [2:0] {
    StIdle,
    StWaitFrame,
    StWaitLine,
    StByte1,
    StByte2,
    StFrameEnd
  } cap_state_e;

endpackage

// File: rtl/cam_rgb565_capture_rgb565_to_rgb444.sv
// Combinational RGB565 byte pair to 12-bit {R,G,B} nibble word.
module rgb565_to_rgb444
  import cam_rgb565_capture_pkg::*;
(
  input  logic [7:0]  byte1_i,
  input  logic [7:0]  byte2_i,
  output logic [11:0] rgb444_o
);

  logic unused_lsbs;

  always_comb begin
    rgb444_o = {byte1_i[R_HI:R_LO], byte1_i[G1_HI:G1_LO], byte2_i[G2_BIT],
                byte2_i[B_HI:B_LO]};
  end

  assign unused_lsbs = ^{byte1_i[3], byte2_i[6:5], byte2_i[0]};

endmodule

// File: rtl/cam_rgb565_capture.sv
// Camera PCLK-domain capture: deserialises RGB565 byte pairs into RGB444 words and
// drives the frame buffer write port with linear row*H_PIX+col addressing.
module cam_rgb565_capture
  import cam_rgb565_capture_pkg::*;
#(
  parameter int unsigned AW    = 15,
  parameter int unsigned DW    = 12,
  parameter int unsigned H_PIX = FRAME_W,
  parameter int unsigned V_PIX = FRAME_H
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable_i,
  input  logic          vsync_i,
  input  logic          href_i,
  input  logic [7:0]    px_data_i,
  output logic [AW-1:0] mem_px_addr_o,
  output logic [DW-1:0] mem_px_data_o,
  output logic          px_wr_o,
  output logic          frame_done_o,
  output logic          overrun_o
);

  localparam int unsigned CW       = $clog2(H_PIX + 1);
  localparam int unsigned RW       = $clog2(V_PIX + 1);
  localparam int unsigned LastAddr = H_PIX * V_PIX - 1;

  cap_state_e    state_q;
  logic          vsync_q;
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic [AW-1:0] line_base_q;
  logic [7:0]    byte1_q;
  logic [AW-1:0] mem_px_addr_q;
  logic [DW-1:0] mem_px_data_q;
  logic          px_wr_q;
  logic          frame_done_q;
  logic          overrun_q;

  logic [11:0]   pix444;
  logic          line_full;
  logic          frame_full;

  rgb565_to_rgb444 u_conv (
    .byte1_i  (byte1_q),
    .byte2_i  (px_data_i),
    .rgb444_o (pix444)
  );

  assign line_full  = (col_q == CW'(H_PIX));
  assign frame_full = (row_q == RW'(V_PIX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      vsync_q       <= 1'b0;
      col_q         <= '0;
      row_q         <= '0;
      line_base_q   <= '0;
      byte1_q       <= '0;
      mem_px_addr_q <= '0;
      mem_px_data_q <= '0;
      px_wr_q       <= 1'b0;
      frame_done_q  <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      vsync_q      <= vsync_i;
      px_wr_q      <= 1'b0;
      frame_done_q <= 1'b0;

      // Post-write increment; saturates so the address never leaves the frame.
      if (px_wr_q && (mem_px_addr_q != AW'(LastAddr))) begin
        mem_px_addr_q <= mem_px_addr_q + 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (vsync_i && enable_i) begin
            state_q <= StWaitFrame;
          end
        end

        StWaitFrame: begin
          mem_px_addr_q <= '0;
          col_q         <= '0;
          row_q         <= '0;
          line_base_q   <= '0;
          overrun_q     <= 1'b0;
          if (vsync_q && !vsync_i) begin
            state_q <= StWaitLine;
          end
        end

        StWaitLine: begin
          if (vsync_i) begin
            state_q <= StFrameEnd;
          end else if (href_i) begin
            byte1_q <= px_data_i;
            state_q <= StByte2;
          end
        end

        StByte1: begin
          if (vsync_i) begin
            state_q <= StFrameEnd;
          end else if (href_i) begin
            byte1_q <= px_data_i;
            state_q <= StByte2;
          end else begin
            col_q   <= '0;
            state_q <= StWaitLine;
            if (!frame_full) begin
              row_q       <= row_q + 1'b1;
              line_base_q <= line_base_q + AW'(H_PIX);
            end
          end
        end

        StByte2: begin
          if (vsync_i) begin
            state_q <= StFrameEnd;
          end else if (href_i) begin
            state_q <= StByte1;
            if (line_full || frame_full) begin
              overrun_q <= 1'b1;
            end else begin
              px_wr_q       <= 1'b1;
              mem_px_data_q <= DW'(pix444);
              mem_px_addr_q <= line_base_q + AW'(col_q);
              col_q         <= col_q + 1'b1;
            end
          end else begin
            // Line ended with only byte1 seen: the half pixel is dropped.
            col_q   <= '0;
            state_q <= StWaitLine;
            if (!frame_full) begin
              row_q       <= row_q + 1'b1;
              line_base_q <= line_base_q + AW'(H_PIX);
            end
          end
        end

        StFrameEnd: begin
          frame_done_q <= frame_full && !overrun_q;
          state_q      <= enable_i ? StWaitFrame : StIdle;
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign mem_px_addr_o = mem_px_addr_q;
  assign mem_px_data_o = mem_px_data_q;
  assign px_wr_o       = px_wr_q;
  assign frame_done_o  = frame_done_q;
  assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_cam_rgb565_capture.sv
// Bench for cam_rgb565_capture: a frame-level model queues the writes each pixel must
// produce; a negedge checker compares every buffer write and frame_done pulse against it.
module tb_cam_rgb565_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        vsync;
  logic        href;
  logic [7:0]  px_data;
  logic [14:0] mem_px_addr;
  logic [11:0] mem_px_data;
  logic        px_wr;
  logic        frame_done;
  logic        overrun;

  cam_rgb565_capture #(
    .AW    (15),
    .DW    (12),
    .H_PIX (160),
    .V_PIX (120)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable_i      (enable),
    .vsync_i       (vsync),
    .href_i        (href),
    .px_data_i     (px_data),
    .mem_px_addr_o (mem_px_addr),
    .mem_px_data_o (mem_px_data),
    .px_wr_o       (px_wr),
    .frame_done_o  (frame_done),
    .overrun_o     (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  wr_t exp_q[$];
  wr_t chk_e;
  int  pass_cnt  = 0;
  int  total_cnt = 0;
  int  wr_cnt    = 0;
  int  done_cnt  = 0;
  int  exp_done  = 0;
  int  last_addr = -1;
  int  last_data = -1;
  int  m_row     = 0;
  int  m_col     = 0;
  bit  m_active  = 1'b0;
  bit  m_ovr     = 1'b0;
  int  w0;
  int  d0;

  task automatic check(string name, int act, int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
  endtask

  // RGB565 -> RGB444 by arithmetic on the byte values.
  function automatic int conv(int b1, int b2);
    int r = b1 / 16;
    int g = (b1 % 8) * 2 + b2 / 128;
    int b = (b2 % 32) / 2;
    return r * 256 + g * 16 + b;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (px_wr || frame_done) check("wr_done_exclusive", int'(px_wr && frame_done), 0);
      if (frame_done) done_cnt++;
      if (px_wr) begin
        wr_cnt++;
        last_addr = int'(mem_px_addr);
        last_data = int'(mem_px_data);
        if (exp_q.size() == 0) begin
          check("unexpected_write_addr", int'(mem_px_addr), -1);
        end else begin
          chk_e = exp_q.pop_front();
          check("wr_addr", int'(mem_px_addr), chk_e.addr);
          check("wr_data", int'(mem_px_data), chk_e.data);
        end
      end
    end
  end

  task automatic drive(logic v, logic h, logic [7:0] d);
    vsync   = v;
    href    = h;
    px_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic model_pixel(int b1, int b2);
    if (m_active) begin
      if (m_row < 120 && m_col < 160) exp_q.push_back('{addr: m_row * 160 + m_col,
                                                         data: conv(b1, b2)});
      else m_ovr = 1'b1;
      m_col++;
    end
  endtask

  task automatic pixel(int b1, int b2);
    model_pixel(b1, b2);
    drive(1'b0, 1'b1, 8'(b1));
    drive(1'b0, 1'b1, 8'(b2));
  endtask

  task automatic end_line();
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    if (m_active) m_row++;
    m_col = 0;
  endtask

  task automatic send_line(int n, bit pattern);
    for (int c = 0; c < n; c++) begin
      if (pattern) pixel((m_row * 7 + c * 3) % 256, (c * 13 + m_row) % 256);
      else pixel(255, 255);
    end
    end_line();
  endtask

  // Ends the current frame (if capturing) and starts the next one.
  task automatic vsync_pulse();
    if (m_active) begin
      check("overrun_at_frame_end", int'(overrun), int'(m_ovr));
      if (m_row == 120 && !m_ovr) exp_done++;
    end
    repeat (4) drive(1'b1, 1'b0, 8'h00);
    check("frame_done_count", done_cnt, exp_done);
    repeat (2) drive(1'b0, 1'b0, 8'h00);
    m_active = enable;
    m_row    = 0;
    m_col    = 0;
    m_ovr    = 1'b0;
    if (m_active) check("overrun_cleared", int'(overrun), 0);
  endtask

  initial begin
    rst_n   = 1'b0;
    enable  = 1'b0;
    vsync   = 1'b0;
    href    = 1'b0;
    px_data = 8'h00;
    #3;
    check("rst_px_wr", int'(px_wr), 0);
    check("rst_addr", int'(mem_px_addr), 0);
    check("rst_data", int'(mem_px_data), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_overrun", int'(overrun), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Frames arrive while capture is disabled.
    vsync_pulse();
    send_line(4, 1'b1);
    send_line(4, 1'b1);
    vsync_pulse();
    check("idle_wr_count", wr_cnt, 0);
    check("idle_addr", int'(mem_px_addr), 0);

    // Single pixel and its one-cycle latency.
    enable = 1'b1;
    vsync_pulse();
    model_pixel(8'hF8, 8'h1F);
    drive(1'b0, 1'b1, 8'hF8);
    check("no_wr_after_byte1", int'(px_wr), 0);
    drive(1'b0, 1'b1, 8'h1F);
    check("single_px_wr", int'(px_wr), 1);
    check("single_px_data", int'(mem_px_data), 12'hF0F);
    check("single_px_addr", int'(mem_px_addr), 0);
    end_line();
    vsync_pulse();

    // Overlong line.
    send_line(161, 1'b1);
    check("overlong_overrun", int'(overrun), 1);
    model_pixel(8'h3C, 8'hA5);
    drive(1'b0, 1'b1, 8'h3C);
    drive(1'b0, 1'b1, 8'hA5);
    check("next_line_addr", int'(mem_px_addr), 160);
    end_line();
    vsync_pulse();

    // Full frame of white.
    w0 = wr_cnt;
    for (int r = 0; r < 120; r++) send_line(160, 1'b0);
    check("full_last_addr", last_addr, 19199);
    check("full_last_data", last_data, 12'hFFF);
    check("full_wr_count", wr_cnt - w0, 19200);
    check("full_overrun", int'(overrun), 0);
    d0 = done_cnt;
    vsync_pulse();
    check("full_done_once", done_cnt - d0, 1);

    // Early vsync after 50 lines, first one overlong.
    d0 = done_cnt;
    send_line(161, 1'b1);
    for (int r = 1; r < 50; r++) send_line(160, 1'b1);
    check("early_overrun", int'(overrun), 1);
    vsync_pulse();
    check("early_no_done", done_cnt - d0, 0);
    model_pixel(8'h12, 8'h34);
    drive(1'b0, 1'b1, 8'h12);
    drive(1'b0, 1'b1, 8'h34);
    check("restart_addr", int'(mem_px_addr), 0);
    check("restart_data", int'(mem_px_data), 12'h14A);
    end_line();

    // enable drops mid-frame: frame completes, then capture stops.
    send_line(3, 1'b1);
    enable = 1'b0;
    send_line(3, 1'b1);
    vsync_pulse();
    w0 = wr_cnt;
    send_line(3, 1'b1);
    vsync_pulse();
    send_line(3, 1'b1);
    check("disabled_no_writes", wr_cnt - w0, 0);

    // Asynchronous reset in the middle of a write.
    enable = 1'b1;
    vsync_pulse();
    pixel(8'h55, 8'hAA);
    end_line();
    drive(1'b0, 1'b1, 8'h12);
    drive(1'b0, 1'b1, 8'h34);
    check("pre_rst_px_wr", int'(px_wr), 1);
    check("pre_rst_addr", int'(mem_px_addr), 160);
    rst_n = 1'b0;
    #1;
    check("async_rst_px_wr", int'(px_wr), 0);
    check("async_rst_addr", int'(mem_px_addr), 0);
    check("async_rst_data", int'(mem_px_data), 0);
    exp_q.delete();
    m_active = 1'b0;
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    rst_n = 1'b1;
    w0 = wr_cnt;
    send_line(3, 1'b1);
    check("post_rst_no_capture", wr_cnt - w0, 0);
    vsync_pulse();
    send_line(2, 1'b1);
    vsync_pulse();

    check("pending_writes", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/cam_rgb565_capture.md
Name: cam_rgb565_capture

Overview:
- Upstream stage of the dual-port frame buffer.
- Deserialises the 8-bit camera pixel bus (RGB565, two bytes per pixel, qualified by VSYNC/HREF) into 12-bit RGB444 words.
- Drives the buffer write port (address, data, write strobe) for a 160x120 frame, linear address = row*160 + col.
- Runs entirely in the camera PCLK domain; the buffer's write clock is the same clock.

Parameters:
AW, 15, write address width (matches buffer)
DW, 12, pixel word width, RGB444
H_PIX, 160, pixels per line
V_PIX, 120, lines per frame

Ports:
clk  in  1  camera PCLK; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
enable  in  1  capture enable; sampled on frame boundary only
vsync  in  1  camera VSYNC, active high = frame gap
href  in  1  camera HREF, high = valid line bytes
px_data  in  8  camera data bus
mem_px_addr  out  AW  buffer write address
mem_px_data  out  DW  buffer write data {R[3:0],G[3:0],B[3:0]}
px_wr  out  1  buffer write strobe (regwrite), one cycle per pixel
frame_done  out  1  one-cycle pulse after last pixel of a complete frame
overrun  out  1  sticky: line >H_PIX pixels or frame >V_PIX lines seen; cleared by reset or new frame start

Behaviour:
- Reset (async, rst_n=0): state=IDLE; mem_px_addr=0, mem_px_data=0, px_wr=0, frame_done=0, overrun=0, col=0, row=0, byte latch=0.
- Inputs vsync/href/px_data sampled directly on clk rising edge (already PCLK-synchronous; no synchronisers).
- States:
  IDLE: wait for vsync=1 with enable=1 -> WAIT_FRAME.
  WAIT_FRAME: addr=0, col=0, row=0, overrun cleared; on vsync falling (1->0) -> WAIT_LINE.
  WAIT_LINE: on href=1 -> latch px_data as byte1 -> BYTE2. On vsync=1 -> FRAME_END.
  BYTE1: href=1 -> latch byte1 -> BYTE2; href=0 -> end of line: row++, col=0 -> WAIT_LINE.
  BYTE2: href=1 -> form pixel, issue write -> BYTE1; href=0 mid-pixel -> discard byte1, treat as end of line.
  FRAME_END: pulse frame_done if row==V_PIX and no overrun; enable=1 -> WAIT_FRAME, else IDLE.
- Conversion (byte1=RRRRRGGG, byte2=GGGBBBBB): R=byte1[7:4], G={byte1[2:0],byte2[7]}, B=byte2[4:1].
- Write timing: px_wr=1 and mem_px_data valid in the cycle after byte2 is sampled; mem_px_addr holds the pixel's address during that cycle, increments by 1 after the write.
- Latency: byte2 sample edge -> px_wr high: 1 clk. Back-to-back pixels produce px_wr every 2 clks.
- Boundaries:
  col==H_PIX: further pixels on the line are not written, overrun=1.
  row==V_PIX: no further writes, overrun=1.
  Address never exceeds H_PIX*V_PIX-1 (19199).
- vsync=1 in any capture state aborts the frame -> FRAME_END; frame_done stays 0 if row<V_PIX.
- enable deassert mid-frame: current frame completes; IDLE entered at FRAME_END.
- Reset mid-frame: outputs go to reset values immediately; capture resumes only after the next vsync with enable=1.
- frame_done and px_wr never high in the same cycle.

Decomposition:
- Shared package: H_PIX, V_PIX, FRAME_PIXELS=19200, state encoding constants, RGB565->RGB444 bit-slice positions.
- One natural sub-module: rgb565_to_rgb444 (combinational slice, reused by test-pattern generator).
- FSM, counters and write-port register stay in the top module.

Test Plan:
- Reset: rst_n=0 asynchronously mid-line -> px_wr=0, mem_px_addr=0, state IDLE within same cycle, no clock required.
- Single pixel: enable=1, vsync pulse, href=1 with bytes 0xF8, 0x1F -> px_wr=1 one clk later, mem_px_data=12'hF0F, addr=0.
- Full frame: 120 lines x 160 pixels of 0xFF,0xFF -> 19200 writes of 12'hFFF, last addr=19199, frame_done=1 once, overrun=0.
- Overlong line: 161 pixels on line 0 -> 160 writes, addr of next line's first pixel=160, overrun=1.
- Early vsync: vsync rises after 50 lines -> no frame_done, next frame restarts at addr 0, overrun cleared.
- enable=0 in IDLE with frames running -> px_wr never asserted, addr stays 0.
